// File: rtl/alu_fu_pipe.sv
// Pipelined integer ALU functional unit: fixed-latency execute pipe feeding an output queue
// that broadcasts {tag, data, illegal} on the CDB under a grant handshake.
module alu_fu_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned TAG_W    = 3,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned OQ_DEPTH = 4
) (
    input  logic                        clk1,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [WIDTH-1:0]            issue_data1,
    input  logic [WIDTH-1:0]            issue_data2,
    input  logic [2:0]                  issue_fun3,
    input  logic [6:0]                  issue_fun7,
    input  logic [TAG_W-1:0]            issue_des,
    output logic                        cdb_valid,
    input  logic                        cdb_grant,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [WIDTH-1:0]            cdb_data,
    output logic                        cdb_illegal,
    output logic                        busy,
    output logic [$clog2(OQ_DEPTH):0]   count
);

    localparam int unsigned CW = $clog2(OQ_DEPTH) + 1;
    localparam int unsigned AW = $clog2(OQ_DEPTH);
    localparam int unsigned SW = $clog2(WIDTH);

    logic             w_acc;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_res;
    logic             w_ill;
    logic [SW-1:0]    w_shamt;

    logic             r_pv   [LATENCY];
    logic [TAG_W-1:0] r_ptag [LATENCY];
    logic [WIDTH-1:0] r_pdata[LATENCY];
    logic             r_pill [LATENCY];

    logic [TAG_W-1:0] r_qtag [OQ_DEPTH];
    logic [WIDTH-1:0] r_qdata[OQ_DEPTH];
    logic             r_qill [OQ_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_qcnt;
    logic [CW-1:0]    r_count;

    // Credits cover pipeline plus queue, so a pipeline output always finds a free slot.
    assign issue_ready = (r_count < CW'(OQ_DEPTH)) && !flush;
    assign w_acc       = issue_valid && issue_ready;
    assign w_push      = r_pv[LATENCY-1];
    assign cdb_valid   = (r_qcnt != '0);
    assign w_pop       = cdb_valid && cdb_grant && !flush;
    assign busy        = (r_count != '0);
    assign count       = r_count;
    assign cdb_tag     = cdb_valid ? r_qtag[r_rptr]  : '0;
    assign cdb_data    = cdb_valid ? r_qdata[r_rptr] : '0;
    assign cdb_illegal = cdb_valid ? r_qill[r_rptr]  : 1'b0;
    assign w_shamt     = issue_data2[SW-1:0];

    always_comb begin
        w_res = '0;
        w_ill = 1'b0;
        case ({issue_fun7, issue_fun3})
            {7'b0000000, 3'b000}: w_res = issue_data1 + issue_data2;
            {7'b0100000, 3'b000}: w_res = issue_data1 - issue_data2;
            {7'b0000000, 3'b111}: w_res = issue_data1 & issue_data2;
            {7'b0000000, 3'b110}: w_res = issue_data1 | issue_data2;
            {7'b0000000, 3'b100}: w_res = issue_data1 ^ issue_data2;
            {7'b0000000, 3'b010}:
                w_res = {{(WIDTH-1){1'b0}}, $signed(issue_data1) < $signed(issue_data2)};
            {7'b0000000, 3'b011}: w_res = {{(WIDTH-1){1'b0}}, issue_data1 < issue_data2};
            {7'b0000000, 3'b001}: w_res = issue_data1 << w_shamt;
            {7'b0000000, 3'b101}: w_res = issue_data1 >> w_shamt;
            {7'b0100000, 3'b101}: w_res = $unsigned($signed(issue_data1) >>> w_shamt);
            default:              w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_pv[i]    <= 1'b0;
                r_ptag[i]  <= '0;
                r_pdata[i] <= '0;
                r_pill[i]  <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_acc;
            if (w_acc) begin
                r_ptag[0]  <= issue_des;
                r_pdata[0] <= w_res;
                r_pill[0]  <= w_ill;
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_ptag[i]  <= r_ptag[i-1];
                r_pdata[i] <= r_pdata[i-1];
                r_pill[i]  <= r_pill[i-1];
            end
            if (flush) begin
                for (int unsigned i = 0; i < LATENCY; i++) r_pv[i] <= 1'b0;
            end
        end
    end

    // When full, a same-cycle push and pop share a slot: the head is read before it is rewritten.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < OQ_DEPTH; i++) begin
                r_qtag[i]  <= '0;
                r_qdata[i] <= '0;
                r_qill[i]  <= 1'b0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_qcnt  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_qcnt  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_qtag[r_wptr]  <= r_ptag[LATENCY-1];
                r_qdata[r_wptr] <= r_pdata[LATENCY-1];
                r_qill[r_wptr]  <= r_pill[LATENCY-1];
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_qcnt  <= r_qcnt + CW'(w_push) - CW'(w_pop);
            r_count <= r_count + CW'(w_acc) - CW'(w_pop);
        end
    end

endmodule

// File: tb/tb_alu_fu_pipe.sv
// Directed self-checking bench for alu_fu_pipe (WIDTH=32, TAG_W=3, LATENCY=2, OQ_DEPTH=4).
module tb_alu_fu_pipe;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_data1;
    logic [31:0] issue_data2;
    logic [2:0]  issue_fun3;
    logic [6:0]  issue_fun7;
    logic [2:0]  issue_des;
    logic        cdb_valid;
    logic        cdb_grant;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_illegal;
    logic        busy;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    alu_fu_pipe #(
        .WIDTH(32), .TAG_W(3), .LATENCY(2), .OQ_DEPTH(4)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_data1(issue_data1), .issue_data2(issue_data2),
        .issue_fun3(issue_fun3), .issue_fun7(issue_fun7), .issue_des(issue_des),
        .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_illegal(cdb_illegal), .busy(busy), .count(count)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [2:0] tag);
        issue_data1 = a;
        issue_data2 = b;
        issue_fun3  = f3;
        issue_fun7  = f7;
        issue_des   = tag;
    endtask

    // Issue one op with grant held high and record every broadcast over the next 8 cycles.
    task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [2:0] tag,
                              output int seen, output int lat, output logic [2:0] otag,
                              output logic [31:0] odata, output logic oill);
        seen  = 0;
        lat   = -1;
        otag  = '0;
        odata = '0;
        oill  = 1'b0;
        set_op(a, b, f3, f7, tag);
        issue_valid = 1'b1;
        cdb_grant   = 1'b1;
        tick();
        issue_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (cdb_valid) begin
                if (seen == 0) begin
                    lat   = k;
                    otag  = cdb_tag;
                    odata = cdb_data;
                    oill  = cdb_illegal;
                end
                seen++;
            end
        end
        cdb_grant = 1'b0;
    endtask

    task automatic test_reset;
        int stale;
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_illegal, busy, count, issue_ready} !==
            {1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b tag=%0d data=%h ill=%b busy=%b count=%0d rdy=%b",
                     cdb_valid, cdb_tag, cdb_data, cdb_illegal, busy, count, issue_ready);
        end
        rst_n = 1'b1;
        tick();
        // Two ops in flight, then an asynchronous reset between edges.
        issue_valid = 1'b1;
        set_op(32'd1, 32'd2, 3'b000, 7'b0, 3'd1);
        tick();
        set_op(32'd3, 32'd4, 3'b000, 7'b0, 3'd2);
        tick();
        issue_valid = 1'b0;
        n_tests++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_pre_count: got %0d want 2", count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({cdb_valid, count, issue_ready, busy} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b count=%0d rdy=%b busy=%b want 0 0 1 0",
                     cdb_valid, count, issue_ready, busy);
        end
        tick();
        rst_n     = 1'b1;
        cdb_grant = 1'b1;
        stale     = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (cdb_valid || count != 0) stale++;
        end
        cdb_grant = 1'b0;
        n_tests++;
        if (stale !== 0) begin
            n_fail++;
            $display("FAIL reset_no_stale: got %0d stale cycles want 0", stale);
        end
    endtask

    task automatic test_ops;
        logic [31:0] va [13] = '{32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd5,
                                 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd1, 32'h80000000,
                                 32'd5, 32'd1};
        logic [31:0] vb [13] = '{32'd7, 32'd7, 32'd1, 32'd1, 32'd4, 32'd7,
                                 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'd33, 32'd4,
                                 32'd7, 32'hFFFFFFFF};
        logic [2:0]  vf3[13] = '{3'b000, 3'b000, 3'b010, 3'b011, 3'b101, 3'b000,
                                 3'b111, 3'b110, 3'b100, 3'b001, 3'b101, 3'b001, 3'b011};
        logic [6:0]  vf7[13] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h20, 7'h01,
                                 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
        logic [31:0] vr [13] = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'd0,
                                 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'd2, 32'h08000000,
                                 32'd0, 32'd1};
        logic        vil[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int          seen;
        int          lat;
        logic [2:0]  otag;
        logic [31:0] odata;
        logic        oill;
        logic [2:0]  tag;
        for (int i = 0; i < 13; i++) begin
            tag = (i == 0) ? 3'd3 : 3'(i);
            run_single(va[i], vb[i], vf3[i], vf7[i], tag, seen, lat, otag, odata, oill);
            n_tests++;
            if (seen !== 1 || lat !== 2) begin
                n_fail++;
                $display("FAIL op%0d_timing: got seen=%0d lat=%0d want seen=1 lat=2",
                         i, seen, lat);
            end
            n_tests++;
            if ({otag, odata, oill} !== {tag, vr[i], vil[i]}) begin
                n_fail++;
                $display("FAIL op%0d_result: got tag=%0d data=%h ill=%b want tag=%0d data=%h ill=%b",
                         i, otag, odata, oill, tag, vr[i], vil[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int bad;
        cdb_grant   = 1'b0;
        issue_valid = 1'b1;
        bad         = 0;
        for (int i = 0; i < 4; i++) begin
            if (issue_ready !== 1'b1) bad++;
            set_op(32'(i * 16 + 1), 32'd2, 3'b000, 7'b0, 3'(i));
            tick();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_ready_before_full: %0d cycles not ready, want 0", bad);
        end
        n_tests++;
        if ({issue_ready, count, busy} !== {1'b0, 3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_full: rdy=%b count=%0d busy=%b want 0 4 1", issue_ready, count, busy);
        end
        // Held issue_valid with no credit must not be accepted.
        set_op(32'd99, 32'd99, 3'b000, 7'b0, 3'd7);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k >= 1 && (cdb_valid !== 1'b1 || cdb_tag !== 3'd0 || cdb_data !== 32'd3)) bad++;
        end
        issue_valid = 1'b0;
        n_tests++;
        if (bad !== 0 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL bp_stable_head: %0d unstable cycles count=%0d want 0 and 4", bad, count);
        end
        cdb_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_illegal} !==
                {1'b1, 3'(i), 32'(i * 16 + 3), 1'b0}) begin
                n_fail++;
                $display("FAIL bp_drain%0d: got v=%b tag=%0d data=%h want v=1 tag=%0d data=%h",
                         i, cdb_valid, cdb_tag, cdb_data, i, i * 16 + 3);
            end
            tick();
        end
        cdb_grant = 1'b0;
        n_tests++;
        if ({cdb_valid, count} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL bp_empty: valid=%b count=%0d want 0 0", cdb_valid, count);
        end
    endtask

    task automatic test_back_to_back;
        int got;
        int first;
        int last;
        int bad_rdy;
        int bad_cnt;
        int bad_res;
        got = 0; first = -1; last = -1; bad_rdy = 0; bad_cnt = 0; bad_res = 0;
        cdb_grant = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c < 10) begin
                set_op(32'(c), 32'd1000, 3'b000, 7'b0, 3'(c % 8));
                issue_valid = 1'b1;
                if (issue_ready !== 1'b1) bad_rdy++;
            end else begin
                issue_valid = 1'b0;
            end
            tick();
            if (count > 3'd3) bad_cnt++;
            if (cdb_valid) begin
                if (cdb_tag !== 3'(got % 8) || cdb_data !== 32'(got + 1000)) bad_res++;
                if (first < 0) first = c;
                last = c;
                got++;
            end
        end
        cdb_grant = 1'b0;
        n_tests++;
        if (bad_rdy !== 0 || bad_cnt !== 0) begin
            n_fail++;
            $display("FAIL b2b_credit: not-ready=%0d count-over=%0d want 0 0", bad_rdy, bad_cnt);
        end
        n_tests++;
        if (got !== 10 || last - first !== 9 || bad_res !== 0) begin
            n_fail++;
            $display("FAIL b2b_stream: got=%0d span=%0d bad=%0d want 10 9 0",
                     got, last - first, bad_res);
        end
    endtask

    task automatic test_flush;
        int stale;
        int seen;
        int lat;
        logic [2:0]  otag;
        logic [31:0] odata;
        logic        oill;
        cdb_grant   = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(32'(i), 32'd1, 3'b000, 7'b0, 3'(i));
            tick();
        end
        n_tests++;
        if ({cdb_valid, count} !== {1'b1, 3'd4}) begin
            n_fail++;
            $display("FAIL flush_pre: valid=%b count=%0d want 1 4", cdb_valid, count);
        end
        flush     = 1'b1;
        cdb_grant = 1'b1;
        set_op(32'd50, 32'd50, 3'b000, 7'b0, 3'd6);
        #1;
        n_tests++;
        if (issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got %b want 0", issue_ready);
        end
        tick();
        flush       = 1'b0;
        issue_valid = 1'b0;
        cdb_grant   = 1'b0;
        n_tests++;
        if ({cdb_valid, count, busy} !== {1'b0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_after: valid=%b count=%0d busy=%b want 0 0 0",
                     cdb_valid, count, busy);
        end
        cdb_grant = 1'b1;
        stale     = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (cdb_valid) stale++;
        end
        n_tests++;
        if (stale !== 0) begin
            n_fail++;
            $display("FAIL flush_no_stale: got %0d broadcasts want 0", stale);
        end
        run_single(32'd1, 32'd1, 3'b000, 7'b0, 3'd5, seen, lat, otag, odata, oill);
        n_tests++;
        if (seen !== 1 || {otag, odata, oill} !== {3'd5, 32'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_reissue: seen=%0d tag=%0d data=%h ill=%b want 1 5 2 0",
                     seen, otag, odata, oill);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        cdb_grant   = 1'b0;
        set_op(32'd0, 32'd0, 3'b000, 7'b0, 3'd0);
        test_reset();
        test_ops();
        test_backpressure();
        test_back_to_back();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
